// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, ALU op codes and the decoded-instruction record.
package riscv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  // Everything the execute stage needs for one instruction.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } dec_t;

  // funct3 to ALU op; alt selects SUB/SRA on the 000/101 slots.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_decoder.sv
// Combinational RV32I integer-computational decoder: operands, ALU op, rd.
module riscv_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output dec_t        dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};

  // Select operands and ALU op by opcode; illegal encodings collapse to a zeroed ADD.
  always_comb begin
    logic legal;
    legal         = 1'b0;
    dec.a         = 32'd0;
    dec.b         = 32'd0;
    dec.alu_ctrl  = ALU_ADD;
    dec.rd        = instr[11:7];
    dec.reg_write = 1'b0;
    dec.illegal   = 1'b0;
    case (opcode)
      OP_LUI: begin
        legal = 1'b1;
        dec.b = imm_u;
      end
      OP_AUIPC: begin
        legal = 1'b1;
        dec.a = pc;
        dec.b = imm_u;
      end
      OP_IMM: begin
        dec.a = rs1_data;
        if (funct3 == 3'b001) begin
          legal        = (funct7 == F7_BASE);
          dec.b        = shamt;
          dec.alu_ctrl = ALU_SLL;
        end else if (funct3 == 3'b101) begin
          legal        = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          dec.b        = shamt;
          dec.alu_ctrl = alu_from_f3(funct3, funct7 == F7_ALT);
        end else begin
          legal        = 1'b1;
          dec.b        = imm_i;
          dec.alu_ctrl = alu_from_f3(funct3, 1'b0);
        end
      end
      OP_REG: begin
        legal        = (funct7 == F7_BASE) ||
                       ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec.a        = rs1_data;
        dec.b        = rs2_data;
        dec.alu_ctrl = alu_from_f3(funct3, funct7 == F7_ALT);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.a        = 32'd0;
      dec.b        = 32'd0;
      dec.alu_ctrl = ALU_ADD;
    end
    dec.illegal   = !legal;
    dec.reg_write = legal && (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/riscv_id_stage.sv
// Decode stage: register-file read, decode, and a single-entry valid/ready output register.
module riscv_id_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [3:0]  ex_alu_ctrl,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_illegal,
  output logic [31:0] ex_pc
);

  dec_t        dec;
  dec_t        ex_d, ex_q;
  logic [31:0] pc_d, pc_q;
  logic        ex_valid_d, ex_valid_q;
  logic        load;

  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  riscv_decoder u_decoder (
    .instr    (if_instr),
    .pc       (if_pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dec      (dec)
  );

  // Accept whenever the output slot is empty or drains this cycle; flush does not gate ready.
  assign if_ready = !ex_valid_q || ex_ready;
  assign load     = if_valid && if_ready && !flush;

  // Next state of the output register: flush kills, load replaces, consume empties, else hold.
  always_comb begin
    ex_d       = ex_q;
    pc_d       = pc_q;
    ex_valid_d = ex_valid_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (load) begin
      ex_d       = dec;
      pc_d       = if_pc;
      ex_valid_d = 1'b1;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  // Output pipeline register; data fields are reset only for determinism.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q       <= 1'b0;
      ex_q.a           <= 32'd0;
      ex_q.b           <= 32'd0;
      ex_q.alu_ctrl    <= ALU_ADD;
      ex_q.rd          <= 5'd0;
      ex_q.reg_write   <= 1'b0;
      ex_q.illegal     <= 1'b0;
      pc_q             <= 32'd0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
      pc_q       <= pc_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_a         = ex_q.a;
  assign ex_b         = ex_q.b;
  assign ex_alu_ctrl  = ex_q.alu_ctrl;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_illegal   = ex_q.illegal;
  assign ex_pc        = pc_q;

endmodule
